// File: rtl/cpu_pkg.sv
// Shared definitions for the 16-bit sequencer: FSM states, opcodes and ALU selects.
package cpu_pkg;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_FETCH_HI  = 3'd1,
        ST_FETCH_LO  = 3'd2,
        ST_EXECUTE   = 3'd3,
        ST_WRITEBACK = 3'd4
    } state_t;

    localparam logic [3:0] OP_LOADI = 4'd0;
    localparam logic [3:0] OP_MOV   = 4'd1;
    localparam logic [3:0] OP_ADD   = 4'd2;
    localparam logic [3:0] OP_SUB   = 4'd3;
    localparam logic [3:0] OP_AND   = 4'd4;
    localparam logic [3:0] OP_OR    = 4'd5;
    localparam logic [3:0] OP_JMP   = 4'd6;
    localparam logic [3:0] OP_BEQ   = 4'd7;
    localparam logic [3:0] OP_NOP   = 4'd8;
    localparam logic [3:0] OP_HALT  = 4'd15;

    localparam logic [2:0] ALU_FWD    = 3'b000;
    localparam logic [2:0] ALU_ADDSUB = 3'b001;
    localparam logic [2:0] ALU_AND    = 3'b010;
    localparam logic [2:0] ALU_OR     = 3'b011;

    // Opcodes 9..14 have no meaning; they execute as NOP but are flagged.
    function automatic logic op_is_undefined(input logic [3:0] op);
        return (op >= 4'd9) && (op <= 4'd14);
    endfunction

endpackage

// File: rtl/cpu_decode.sv
// Combinational instruction decode: IR fields and opcode-to-control mapping.
module cpu_decode
    import cpu_pkg::*;
(
    input  logic [15:0] ir,
    output logic [2:0]  alu_op,
    output logic        is_add,
    output logic        is_imm,
    output logic [2:0]  dest,
    output logic [2:0]  src1,
    output logic [2:0]  src2,
    output logic [7:0]  imm,
    output logic        writes_reg,
    output logic        is_jmp,
    output logic        is_beq,
    output logic        is_halt,
    output logic        is_illegal
);

    logic [3:0] opcode;

    assign opcode = ir[15:12];
    assign dest   = ir[11:9];
    assign src1   = ir[8:6];
    assign src2   = ir[2:0];
    assign imm    = ir[7:0];

    always_comb begin
        alu_op     = ALU_FWD;
        is_add     = 1'b1;
        is_imm     = 1'b0;
        writes_reg = 1'b0;
        is_jmp     = 1'b0;
        is_beq     = 1'b0;
        is_halt    = 1'b0;
        is_illegal = 1'b0;
        case (opcode)
            OP_LOADI: begin
                is_imm     = 1'b1;
                writes_reg = 1'b1;
            end
            OP_MOV: writes_reg = 1'b1;
            OP_ADD: begin
                alu_op     = ALU_ADDSUB;
                writes_reg = 1'b1;
            end
            OP_SUB: begin
                alu_op     = ALU_ADDSUB;
                is_add     = 1'b0;
                writes_reg = 1'b1;
            end
            OP_AND: begin
                alu_op     = ALU_AND;
                writes_reg = 1'b1;
            end
            OP_OR: begin
                alu_op     = ALU_OR;
                writes_reg = 1'b1;
            end
            OP_JMP:  is_jmp  = 1'b1;
            OP_BEQ:  is_beq  = 1'b1;
            OP_NOP:  ;
            OP_HALT: is_halt = 1'b1;
            default: is_illegal = op_is_undefined(opcode);
        endcase
    end

endmodule

// File: rtl/cpu_sequencer.sv
// Multi-cycle instruction sequencer: byte-wise fetch, decode, execute and writeback
// control; owns the FSM, pc, IR and the Z flag.
module cpu_sequencer
    import cpu_pkg::*;
(
    input  logic       CLK,
    input  logic       RESET,
    input  logic       run,
    output logic       fetch_req,
    output logic [8:0] fetch_addr,
    input  logic       fetch_valid,
    input  logic [7:0] fetch_data,
    input  logic       alu_zero,
    output logic [2:0] alu_op,
    output logic       is_add,
    output logic       is_imm,
    output logic [7:0] imm,
    output logic [2:0] dest,
    output logic [2:0] src1,
    output logic [2:0] src2,
    output logic       reg_write,
    output logic [7:0] pc,
    output logic       halted,
    output logic       illegal
);

    state_t      state, state_next;
    logic [7:0]  pc_next;
    logic [15:0] ir, ir_next;
    logic        z_flag, z_next;
    logic        byte_sel;
    logic        wb_active;
    logic        illegal_active;

    logic dec_writes_reg, dec_is_jmp, dec_is_beq, dec_is_halt, dec_is_illegal;

    cpu_decode u_decode (
        .ir         (ir),
        .alu_op     (alu_op),
        .is_add     (is_add),
        .is_imm     (is_imm),
        .dest       (dest),
        .src1       (src1),
        .src2       (src2),
        .imm        (imm),
        .writes_reg (dec_writes_reg),
        .is_jmp     (dec_is_jmp),
        .is_beq     (dec_is_beq),
        .is_halt    (dec_is_halt),
        .is_illegal (dec_is_illegal)
    );

    always_ff @(posedge CLK) begin
        if (RESET) begin
            state  <= ST_IDLE;
            pc     <= 8'd0;
            ir     <= 16'd0;
            z_flag <= 1'b0;
        end else begin
            state  <= state_next;
            pc     <= pc_next;
            ir     <= ir_next;
            z_flag <= z_next;
        end
    end

    // Fetch handshake: fetch_req stays high with fetch_addr stable until a cycle
    // with fetch_valid; fetch_data of that same cycle is captured and the request ends.
    always_comb begin
        state_next     = state;
        pc_next        = pc;
        ir_next        = ir;
        z_next         = z_flag;
        fetch_req      = 1'b0;
        byte_sel       = 1'b0;
        wb_active      = 1'b0;
        illegal_active = 1'b0;
        case (state)
            ST_IDLE: begin
                if (run) state_next = ST_FETCH_HI;
            end
            ST_FETCH_HI: begin
                fetch_req = 1'b1;
                if (fetch_valid) begin
                    ir_next[15:8] = fetch_data;
                    state_next    = ST_FETCH_LO;
                end
            end
            ST_FETCH_LO: begin
                fetch_req = 1'b1;
                byte_sel  = 1'b1;
                if (fetch_valid) begin
                    ir_next[7:0] = fetch_data;
                    state_next   = ST_EXECUTE;
                end
            end
            ST_EXECUTE: begin
                illegal_active = dec_is_illegal;
                if (dec_writes_reg) begin
                    state_next = ST_WRITEBACK;
                end else begin
                    state_next = dec_is_halt ? ST_IDLE : ST_FETCH_HI;
                    if (dec_is_jmp || (dec_is_beq && z_flag)) pc_next = imm;
                    else                                      pc_next = pc + 8'd1;
                end
            end
            ST_WRITEBACK: begin
                wb_active  = 1'b1;
                z_next     = alu_zero;
                pc_next    = pc + 8'd1;
                state_next = ST_FETCH_HI;
            end
            default: state_next = ST_IDLE;
        endcase
    end

    // A write coinciding with a sampled reset must never reach the register file.
    assign reg_write  = wb_active & ~RESET;
    assign illegal    = illegal_active & ~RESET;
    assign fetch_addr = {pc, byte_sel};
    assign halted     = (state == ST_IDLE);

endmodule

// File: tb/tb_cpu_sequencer.sv
// Self-checking bench for cpu_sequencer: instruction-level timeline model plus directed checks.
module tb_cpu_sequencer;

    logic       CLK = 1'b0;
    logic       RESET = 1'b1;
    logic       run = 1'b0;
    logic       fetch_valid = 1'b0;
    logic [7:0] fetch_data = 8'd0;
    logic       alu_zero = 1'b0;
    logic       fetch_req;
    logic [8:0] fetch_addr;
    logic [2:0] alu_op;
    logic       is_add, is_imm;
    logic [7:0] imm;
    logic [2:0] dest, src1, src2;
    logic       reg_write;
    logic [7:0] pc;
    logic       halted, illegal;

    cpu_sequencer dut (
        .CLK(CLK), .RESET(RESET), .run(run),
        .fetch_req(fetch_req), .fetch_addr(fetch_addr),
        .fetch_valid(fetch_valid), .fetch_data(fetch_data),
        .alu_zero(alu_zero), .alu_op(alu_op), .is_add(is_add), .is_imm(is_imm),
        .imm(imm), .dest(dest), .src1(src1), .src2(src2),
        .reg_write(reg_write), .pc(pc), .halted(halted), .illegal(illegal)
    );

    always #5 CLK = ~CLK;

    typedef struct {
        logic       fr;
        logic [8:0] fa;
        logic       rw;
        logic       il;
        logic       ha;
        logic [7:0] pc;
        logic       dchk;
        logic [2:0] aop;
        logic       add;
        logic       immf;
        logic [2:0] d, s1, s2;
        logic [7:0] im;
    } row_t;

    row_t        exp_rows[256];
    row_t        cur_row;
    logic [15:0] mem[256];
    int          wait_hi[256];
    int          wait_lo[256];
    logic        zero_tab[256];
    logic        run_tab[256];
    logic [7:0]  obs_pc[256];
    logic        obs_fr[256];
    logic [8:0]  obs_fa[256];
    int          rw_q[$];
    int          il_q[$];
    int          n_rows, n_lim;
    int          checks = 0;
    int          errors = 0;
    logic        active = 1'b0;
    int          cyc = 0;
    int          wait_cnt = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    function automatic int q_at(input int q[$], input int idx);
        if (idx < q.size()) return q[idx];
        return -1;
    endfunction

    task automatic clear_tabs();
        for (int i = 0; i < 256; i++) begin
            mem[i] = 16'h0000; wait_hi[i] = 0; wait_lo[i] = 0;
            zero_tab[i] = 1'b0; run_tab[i] = 1'b1;
        end
    endtask

    // ---------------- model: instruction-level semantics laid out on a cycle timeline
    task automatic push_row(input logic fr, input logic [8:0] fa, input logic rw, input logic il,
                            input logic ha, input logic [7:0] p, input logic dchk, input logic [15:0] ir);
        row_t r;
        logic [3:0] op;
        op     = ir[15:12];
        r.fr   = fr;  r.fa = fa;  r.rw = rw;  r.il = il;  r.ha = ha;  r.pc = p;  r.dchk = dchk;
        r.aop  = (op == 4'd2 || op == 4'd3) ? 3'b001 : (op == 4'd4) ? 3'b010 :
                 (op == 4'd5) ? 3'b011 : 3'b000;
        r.add  = (op != 4'd3);
        r.immf = (op == 4'd0);
        r.d    = ir[11:9];  r.s1 = ir[8:6];  r.s2 = ir[2:0];  r.im = ir[7:0];
        if (n_rows < n_lim) begin
            exp_rows[n_rows] = r;
            n_rows++;
        end
    endtask

    task automatic build_model(input int lim);
        logic [7:0]  mpc;
        logic        z, idle, r;
        logic [15:0] ir;
        logic [3:0]  op;
        n_rows = 0; n_lim = lim; mpc = 8'd0; z = 1'b0; idle = 1'b1;
        while (n_rows < lim) begin
            if (idle) begin
                r = run_tab[n_rows];
                push_row(1'b0, 9'd0, 1'b0, 1'b0, 1'b1, mpc, 1'b0, 16'd0);
                if (r) idle = 1'b0;
            end else begin
                ir = mem[mpc];
                op = ir[15:12];
                for (int i = 0; i <= wait_hi[mpc]; i++)
                    push_row(1'b1, {mpc, 1'b0}, 1'b0, 1'b0, 1'b0, mpc, 1'b0, 16'd0);
                for (int i = 0; i <= wait_lo[mpc]; i++)
                    push_row(1'b1, {mpc, 1'b1}, 1'b0, 1'b0, 1'b0, mpc, 1'b0, 16'd0);
                push_row(1'b0, 9'd0, 1'b0, (op >= 4'd9 && op <= 4'd14), 1'b0, mpc, (op <= 4'd5), ir);
                if (op <= 4'd5) begin
                    push_row(1'b0, 9'd0, 1'b1, 1'b0, 1'b0, mpc, 1'b1, ir);
                    z   = zero_tab[mpc];
                    mpc = mpc + 8'd1;
                end else if (op == 4'd6) begin
                    mpc = ir[7:0];
                end else if (op == 4'd7) begin
                    mpc = z ? ir[7:0] : mpc + 8'd1;
                end else begin
                    mpc = mpc + 8'd1;
                    if (op == 4'd15) idle = 1'b1;
                end
            end
        end
    endtask

    // ---------------- driver
    task automatic do_reset();
        RESET = 1'b1; run = 1'b0; fetch_valid = 1'b0; wait_cnt = 0;
        repeat (2) @(posedge CLK);
        #1 RESET = 1'b0;
    endtask

    task automatic drive_fetch();
        int w;
        if (fetch_req) begin
            w = fetch_addr[0] ? wait_lo[fetch_addr[8:1]] : wait_hi[fetch_addr[8:1]];
            if (wait_cnt >= w) begin
                fetch_valid = 1'b1;
                fetch_data  = fetch_addr[0] ? mem[fetch_addr[8:1]][7:0] : mem[fetch_addr[8:1]][15:8];
                wait_cnt    = 0;
            end else begin
                fetch_valid = 1'b0;
                wait_cnt++;
            end
        end else begin
            fetch_valid = 1'b0;
            wait_cnt    = 0;
        end
        alu_zero = zero_tab[pc];
    endtask

    task automatic run_scenario(input int lim);
        build_model(lim);
        rw_q.delete();
        il_q.delete();
        do_reset();
        for (int c = 0; c < lim; c++) begin
            cyc = c;
            run = run_tab[c];
            drive_fetch();
            active = 1'b1;
            @(posedge CLK);
            #1;
        end
        active = 1'b0;
    endtask

    // ---------------- compare process
    initial begin
        forever begin
            @(negedge CLK);
            if (active) begin
                cur_row = exp_rows[cyc];
                check($sformatf("c%0d fetch_req", cyc), fetch_req, cur_row.fr);
                if (cur_row.fr) check($sformatf("c%0d fetch_addr", cyc), fetch_addr, cur_row.fa);
                check($sformatf("c%0d reg_write", cyc), reg_write, cur_row.rw);
                check($sformatf("c%0d illegal", cyc), illegal, cur_row.il);
                check($sformatf("c%0d halted", cyc), halted, cur_row.ha);
                check($sformatf("c%0d pc", cyc), pc, cur_row.pc);
                if (cur_row.dchk) begin
                    check($sformatf("c%0d alu_op", cyc), alu_op, cur_row.aop);
                    check($sformatf("c%0d is_add", cyc), is_add, cur_row.add);
                    check($sformatf("c%0d is_imm", cyc), is_imm, cur_row.immf);
                    check($sformatf("c%0d dest", cyc), dest, cur_row.d);
                    check($sformatf("c%0d src1", cyc), src1, cur_row.s1);
                    check($sformatf("c%0d src2", cyc), src2, cur_row.s2);
                    check($sformatf("c%0d imm", cyc), imm, cur_row.im);
                end
                obs_pc[cyc] = pc;
                obs_fr[cyc] = fetch_req;
                obs_fa[cyc] = fetch_addr;
                if (reg_write) rw_q.push_back(cyc);
                if (illegal)   il_q.push_back(cyc);
            end
        end
    end

    // ---------------- directed sequence
    initial begin
        int   cnt;
        logic found;

        // LOADI r1,5 then ADD: writes at cycles 4 and 8, pc 2 afterwards
        clear_tabs();
        mem[0] = 16'h0205; mem[1] = 16'h2000; mem[2] = 16'hF000;
        run_scenario(20);
        check("s1 first write cycle", q_at(rw_q, 0), 4);
        check("s1 second write cycle", q_at(rw_q, 1), 8);
        check("s1 pc after two", obs_pc[9], 8'd2);

        // low-byte fetch delayed 3 cycles
        clear_tabs();
        mem[0] = 16'h0205; mem[1] = 16'hF000; wait_lo[0] = 3;
        run_scenario(20);
        cnt = 0;
        for (int i = 0; i < 20; i++) if (obs_fr[i] && obs_fa[i] == 9'h001) cnt++;
        check("s2 low fetch held cycles", cnt, 4);
        check("s2 write cycle", q_at(rw_q, 0), 7);

        // SUB/BEQ taken, then SUB/BEQ not taken
        clear_tabs();
        mem[0]    = 16'h3000; zero_tab[0]    = 1'b1; mem[1]    = 16'h7040;
        mem[8'h40] = 16'h3000; zero_tab[8'h40] = 1'b0; mem[8'h41] = 16'h7080;
        mem[8'h42] = 16'hF000;
        run_scenario(18);
        check("s3 beq taken pc", obs_pc[8], 8'h40);
        check("s3 beq not taken pc", obs_pc[15], 8'h42);

        // JMP 0xFF then NOP wraps to 0
        clear_tabs();
        mem[0] = 16'h60FF; mem[8'hFF] = 16'h8000;
        run_scenario(12);
        check("s4 fetch addr lo at ff", obs_fa[5], 9'h1FF);
        check("s4 pc wrap", obs_pc[7], 8'h00);

        // undefined opcode, then HALT with run low
        clear_tabs();
        mem[0] = 16'hA000; mem[1] = 16'hF000; mem[2] = 16'h1000;
        for (int i = 1; i < 15; i++) run_tab[i] = 1'b0;
        run_scenario(18);
        check("s5 illegal pulses", il_q.size(), 1);
        check("s5 illegal cycle", q_at(il_q, 0), 3);
        check("s5 no writes", rw_q.size(), 0);
        cnt = 0;
        for (int i = 7; i < 16; i++) if (obs_fr[i]) cnt++;
        check("s5 fetch while halted", cnt, 0);
        check("s5 pc after halt", obs_pc[7], 8'd2);
        check("s5 resume fetch addr", obs_fa[16], 9'h004);

        // reset in FETCH_LO
        clear_tabs();
        mem[0] = 16'h0205; mem[1] = 16'h2000; wait_lo[0] = 2;
        do_reset();
        run = 1'b1;
        found = 1'b0;
        for (int c = 0; c < 20 && !found; c++) begin
            drive_fetch();
            if (fetch_req && fetch_addr[0]) begin
                found = 1'b1;
                RESET = 1'b1;
                #1 check("rst_lo reg_write", reg_write, 1'b0);
            end else begin
                @(posedge CLK);
                #1;
            end
        end
        check("rst_lo reached", found, 1'b1);
        @(posedge CLK);
        #1 RESET = 1'b0;
        run = 1'b0;
        check("rst_lo halted", halted, 1'b1);
        check("rst_lo pc", pc, 8'd0);
        check("rst_lo fetch_req", fetch_req, 1'b0);

        // reset in WRITEBACK
        run = 1'b1;
        found = 1'b0;
        for (int c = 0; c < 30 && !found; c++) begin
            @(posedge CLK);
            #1;
            drive_fetch();
            if (reg_write) begin
                found = 1'b1;
                RESET = 1'b1;
                #1 check("rst_wb write suppressed", reg_write, 1'b0);
            end
        end
        check("rst_wb reached", found, 1'b1);
        @(posedge CLK);
        #1 RESET = 1'b0;
        run = 1'b0;
        check("rst_wb halted", halted, 1'b1);
        check("rst_wb pc", pc, 8'd0);
        check("rst_wb reg_write", reg_write, 1'b0);
        check("rst_wb illegal", illegal, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
